// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int C_HDR_BYTES      = 2;
    localparam int C_BYTES_PER_WORD = 4;
    localparam int C_LEN_W          = 8 * C_HDR_BYTES;
    localparam int C_WORD_W         = 8 * C_BYTES_PER_WORD;
    localparam int C_BCNT_W         = $clog2(C_BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_BYTE   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Shifts in bytes MSB-first and flags the final byte of a word.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                accept_i,
    input  logic [7:0]          byte_i,
    output logic [C_WORD_W-1:0] word_o,
    output logic                full_o
);

    logic [C_BCNT_W-1:0] cnt_q, cnt_d;
    logic [C_WORD_W-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        full_o = accept_i && (cnt_q == C_BCNT_W'(C_BYTES_PER_WORD - 1));
        if (clear_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            // The counter wraps naturally after the last byte of each word.
            word_d = {word_q[C_WORD_W-9:0], byte_i};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader streaming a length-prefixed image into imem.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [C_WORD_W-1:0] mem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_loaded
);

    localparam logic [C_LEN_W-1:0] C_DEPTH_LEN = C_LEN_W'(DEPTH);

    state_e               state_q, state_d;
    logic [C_LEN_W-1:0]   count_q, count_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W:0]      words_q, words_d;
    logic                 hold_q, hold_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 w_accept;
    logic                 w_asm_clear;
    logic                 w_asm_full;
    logic [C_LEN_W-1:0]   w_len;
    logic [ADDR_W:0]      w_words_next;

    assign in_ready     = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_BYTE);
    assign w_accept     = in_valid && in_ready;
    assign w_len        = {count_q[C_LEN_W-1:8], in_data};
    assign w_words_next = words_q + 1'b1;

    word_assembler u_word_assembler (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (w_asm_clear),
        .accept_i (w_accept && (state_q == S_BYTE)),
        .byte_i   (in_data),
        .word_o   (mem_wdata),
        .full_o   (w_asm_full)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        addr_d      = addr_q;
        words_d     = words_q;
        hold_d      = hold_q;
        done_d      = done_q;
        error_d     = error_q;
        w_asm_clear = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LEN_HI;
                    hold_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    addr_d      = '0;
                    words_d     = '0;
                    w_asm_clear = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    count_d[C_LEN_W-1:8] = in_data;
                    state_d              = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    count_d[7:0] = in_data;
                    if (w_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else if (w_len > C_DEPTH_LEN) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_BYTE;
                    end
                end
            end
            S_BYTE: begin
                if (w_asm_full) begin
                    state_d  = S_WRITE;
                    mem_we_d = 1'b1;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                words_d = w_words_next;
                if (C_LEN_W'(w_words_next) == count_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = S_BYTE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            words_q  <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = addr_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for the instruction memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int checks;
    int errors;
    int cyc;
    int we_count;
    int stim_timeouts;
    int ready_drops;
    bit monitor_on;

    logic [31:0] mem_model [256];
    logic [31:0] prog [10] = '{32'h20090005, 32'h200A000A, 32'h012A5820, 32'h016A6022,
                               32'h000C6880, 32'hAC0D0000, 32'h8C0E0000, 32'h11CD0001,
                               32'h200F0001, 32'h08000000};

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Behavioural instruction memory plus a watch on in_ready outside WRITE.
    always @(negedge clk) begin
        if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            we_count++;
        end
        if (monitor_on && !in_ready && !mem_we) ready_drops++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) stim_timeouts++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        while (!done && !error && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_done_error: got %b%b want 00", done, error); end
        checks++; if (words_loaded !== 9'd0) begin errors++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL idle_state: ready %b hold %b want 0 1", in_ready, cpu_hold); end
    endtask

    task automatic test_load10();
        bit ok;
        int t0;
        stim_timeouts = 0;
        pulse_start();
        we_count = 0;
        t0 = cyc;
        send_byte(8'h00);
        send_byte(8'h0A);
        for (int i = 0; i < 10; i++) send_word(prog[i]);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL load10_done: done %b error %b want done", done, error); end
        checks++; if (cyc - t0 !== 52) begin errors++; $display("FAIL load10_cycles: got %0d want 52", cyc - t0); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL load10_hold: got %b want 0", cpu_hold); end
        checks++; if (words_loaded !== 9'd10) begin errors++; $display("FAIL load10_words: got %0d want 10", words_loaded); end
        checks++; if (we_count !== 10) begin errors++; $display("FAIL load10_we_count: got %0d want 10", we_count); end
        checks++; if (mem_model[0] !== 32'h20090005) begin errors++; $display("FAIL load10_mem0: got %h want 20090005", mem_model[0]); end
        checks++; if (mem_model[9] !== 32'h08000000) begin errors++; $display("FAIL load10_mem9: got %h want 08000000", mem_model[9]); end
        checks++; if (mem_model[4] !== 32'h000C6880) begin errors++; $display("FAIL load10_mem4: got %h want 000C6880", mem_model[4]); end
        checks++; if (stim_timeouts !== 0) begin errors++; $display("FAIL load10_stall: got %0d timeouts want 0", stim_timeouts); end
    endtask

    task automatic test_zero_len();
        pulse_start();
        we_count = 0;
        send_byte(8'h00);
        send_byte(8'h00);
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_done: done %b hold %b want 1 0", done, cpu_hold); end
        checks++; if (we_count !== 0 || words_loaded !== 9'd0) begin errors++; $display("FAIL zero_writes: we %0d words %0d want 0 0", we_count, words_loaded); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_overflow();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL depth_exact: error %b ready %b want 0 1", error, in_ready); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_start();
        we_count = 0;
        send_byte(8'h01);
        send_byte(8'h01);
        checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ovf_flags: err %b hold %b done %b want 1 1 0", error, cpu_hold, done); end
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", in_ready); end
        checks++; if (we_count !== 0) begin errors++; $display("FAIL ovf_writes: got %0d want 0", we_count); end
        in_valid = 1'b0;
        pulse_start();
        checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ovf_restart: err %b ready %b want 0 1", error, in_ready); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gapped();
        bit ok;
        int t0;
        logic [7:0] bytes [10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        stim_timeouts = 0;
        pulse_start();
        we_count = 0;
        ready_drops = 0;
        monitor_on = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            send_byte(bytes[i]);
            if (i == 9) monitor_on = 1'b0;
            @(negedge clk);
        end
        wait_done(ok);
        checks++; if (!ok || words_loaded !== 9'd2) begin errors++; $display("FAIL gap_done: done %b words %0d want 1 2", done, words_loaded); end
        checks++; if (mem_model[0] !== 32'h11223344 || mem_model[1] !== 32'h55667788) begin errors++; $display("FAIL gap_data: got %h %h want 11223344 55667788", mem_model[0], mem_model[1]); end
        checks++; if (ready_drops !== 0) begin errors++; $display("FAIL gap_ready: got %0d drops want 0", ready_drops); end
        checks++; if (cyc - t0 < 20) begin errors++; $display("FAIL gap_time: got %0d want >= 20", cyc - t0); end
        checks++; if (we_count !== 2 || stim_timeouts !== 0) begin errors++; $display("FAIL gap_writes: we %0d to %0d want 2 0", we_count, stim_timeouts); end
    endtask

    task automatic test_reset_midload();
        bit ok;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || mem_wdata !== 32'h0) begin errors++; $display("FAIL mid_reset: ready %b hold %b wdata %h want 0 1 0", in_ready, cpu_hold, mem_wdata); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_start();
        we_count = 0;
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hDEADBEEF);
        wait_done(ok);
        checks++; if (!ok || words_loaded !== 9'd1) begin errors++; $display("FAIL mid_reload: done %b words %0d want 1 1", done, words_loaded); end
        checks++; if (mem_model[0] !== 32'hDEADBEEF || we_count !== 1) begin errors++; $display("FAIL mid_data: got %h we %0d want DEADBEEF 1", mem_model[0], we_count); end
    endtask

    task automatic test_start_handling();
        bit ok;
        pulse_start();
        we_count = 0;
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hCA);
        send_byte(8'hFE);
        pulse_start();
        checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL byte_start: ready %b hold %b want 1 1", in_ready, cpu_hold); end
        send_byte(8'hBA);
        send_byte(8'hBE);
        send_word(32'h0BADF00D);
        wait_done(ok);
        checks++; if (!ok || words_loaded !== 9'd2) begin errors++; $display("FAIL byte_start_done: done %b words %0d want 1 2", done, words_loaded); end
        checks++; if (mem_model[0] !== 32'hCAFEBABE || mem_model[1] !== 32'h0BADF00D) begin errors++; $display("FAIL byte_start_data: got %h %h want CAFEBABE 0BADF00D", mem_model[0], mem_model[1]); end
        pulse_start();
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL restart_flags: hold %b done %b want 1 0", cpu_hold, done); end
        checks++; if (mem_addr !== 8'h00 || words_loaded !== 9'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL restart_regs: addr %h words %0d ready %b want 00 0 1", mem_addr, words_loaded, in_ready); end
        we_count = 0;
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h12345678);
        wait_done(ok);
        checks++; if (!ok || mem_model[0] !== 32'h12345678 || mem_model[1] !== 32'h0BADF00D) begin errors++; $display("FAIL restart_data: got %h %h want 12345678 0BADF00D", mem_model[0], mem_model[1]); end
        checks++; if (words_loaded !== 9'd1 || we_count !== 1) begin errors++; $display("FAIL restart_words: words %0d we %0d want 1 1", words_loaded, we_count); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        we_count      = 0;
        stim_timeouts = 0;
        ready_drops   = 0;
        monitor_on    = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        test_reset();
        test_load10();
        test_zero_len();
        test_overflow();
        test_gapped();
        test_reset_midload();
        test_start_handling();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
